alu_result_checker: RTL and testbench

Synthesizable in-line checker that consumes the output of the pipelined 4-bit ALU and scores it against a golden model. The stimulus source issues operand/opcode vectors to the ALU and, in the same cycle, to this block. The checker delays each expected result by the ALU pipeline latency and compares it with the ALU's X output. It reports the per-run vector count, error count and first-failure details to the bench or a status register.

---
 rtl/alu_result_checker.sv | 104 ++++++++++
 tb/tb_alu_result_checker.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_checker.sv
// alu_result_checker: scores a pipelined ALU's X output against a golden model delayed by LAT cycles
module alu_result_checker #(
  parameter int W   = 4,
  parameter int LAT = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         in_valid,
  input  logic         in_last,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  input  logic [W-1:0] x,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [7:0]   vec_count,
  output logic [7:0]   err_count,
  output logic [7:0]   first_err_idx,
  output logic [2:0]   first_err_op,
  output logic [W-1:0] first_err_got
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t       r_state, w_next;
  logic         r_v   [LAT];
  logic         r_l   [LAT];
  logic [2:0]   r_op  [LAT];
  logic [W-1:0] r_exp [LAT];
  logic         w_clear, w_cmp, w_miss;
  logic [W-1:0] w_exp;
  logic [7:0]   w_vec_inc, w_err_inc;

  function automatic logic [W-1:0] model(input logic [W-1:0] p, input logic [W-1:0] q, input logic [2:0] o);
    case (o)
      3'b000:  return p + q;
      3'b001:  return p - q;
      3'b010:  return p ^ q;
      3'b011:  return p | q;
      3'b100:  return p & q;
      3'b101:  return ~(p | q);
      3'b110:  return ~(p & q);
      default: return ~(p ^ q);
    endcase
  endfunction

  assign w_exp     = model(a, b, op);
  assign w_clear   = start && (r_state == IDLE || r_state == DONE);
  assign busy      = r_state == RUN || r_state == DRAIN;
  assign done      = r_state == DONE;
  assign pass      = done && err_count == 8'd0;
  assign w_cmp     = busy && r_v[LAT-1];
  assign w_miss    = w_cmp && x != r_exp[LAT-1];
  assign w_vec_inc = (vec_count == 8'hFF) ? vec_count : vec_count + 8'd1;
  assign w_err_inc = (err_count == 8'hFF) ? err_count : err_count + 8'd1;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: w_next = start ? RUN : r_state;
      RUN:        w_next = (in_valid && in_last) ? DRAIN : RUN;
      DRAIN:      w_next = (w_cmp && r_l[LAT-1]) ? DONE : DRAIN;
      default:    w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    r_state <= rst ? IDLE : w_next;
  end

  // Only the valid bits need clearing; payload is ignored while invalid
  always_ff @(posedge clk) begin
    r_v[0]   <= !rst && r_state == RUN && in_valid;
    r_l[0]   <= in_last;
    r_op[0]  <= op;
    r_exp[0] <= w_exp;
    for (int i = 1; i < LAT; i++) begin
      r_v[i]   <= !rst && !w_clear && r_v[i-1];
      r_l[i]   <= r_l[i-1];
      r_op[i]  <= r_op[i-1];
      r_exp[i] <= r_exp[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      vec_count     <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
      first_err_op  <= '0;
      first_err_got <= '0;
    end else if (w_cmp) begin
      vec_count <= w_vec_inc;
      if (w_miss) begin
        err_count <= w_err_inc;
        if (err_count == 8'd0) begin
          first_err_idx <= w_vec_inc;
          first_err_op  <= r_op[LAT-1];
          first_err_got <= x;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_result_checker.sv
// tb_alu_result_checker: random/directed runs, per-run expectations scored by a done-triggered monitor
module tb_alu_result_checker;
  localparam int W   = 4;
  localparam int LAT = 3;

  logic         clk = 0, rst = 1, start = 0, in_valid = 0, in_last = 0;
  logic [W-1:0] a = 0, b = 0, xin = 0, x;
  logic [2:0]   op = 0;
  logic         busy, done, pass;
  logic [7:0]   vec_count, err_count, first_err_idx;
  logic [2:0]   first_err_op;
  logic [W-1:0] first_err_got;
  logic [W-1:0] xp [LAT];

  alu_result_checker #(.W(W), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_last(in_last),
    .a(a), .b(b), .op(op), .x(x), .busy(busy), .done(done), .pass(pass),
    .vec_count(vec_count), .err_count(err_count), .first_err_idx(first_err_idx),
    .first_err_op(first_err_op), .first_err_got(first_err_got)
  );

  always #5 clk = ~clk;

  // Stand-in for the ALU: whatever X the bench chose at issue appears LAT edges later
  always @(posedge clk) begin
    xp[0] <= xin;
    for (int i = 1; i < LAT; i++) xp[i] <= xp[i-1];
  end
  assign x = xp[LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int vec; int err; int idx; int op; int got; int pass; int dcyc;} exp_t;
  exp_t sb[$];
  int errors = 0, checks = 0, last_vec = 0;
  int qa[$], qb[$], qop[$], qx[$], qgap[$];
  bit qst[$];
  logic pd = 0;
  exp_t me;

  function automatic int ref_alu(int p, int q, int o);
    case (o)
      0: return (p + q) % 16;
      1: return (p - q + 16) % 16;
      2: return p ^ q;
      3: return p | q;
      4: return p & q;
      5: return 15 - (p | q);
      6: return 15 - (p & q);
      default: return 15 - (p ^ q);
    endcase
  endfunction

  task automatic chk(string n, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", n, got, want);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (done && !pd) begin
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        me = sb.pop_front();
        chk("vec_count", int'(vec_count), me.vec);
        chk("err_count", int'(err_count), me.err);
        chk("first_err_idx", int'(first_err_idx), me.idx);
        chk("first_err_op", int'(first_err_op), me.op);
        chk("first_err_got", int'(first_err_got), me.got);
        chk("pass", int'(pass), me.pass);
        chk("done_cycle", cyc, me.dcyc);
      end
    end
    pd = done;
  end

  task automatic push_vec(int av, int bv, int o, int xv, int gap = 0, bit st = 0);
    qa.push_back(av); qb.push_back(bv); qop.push_back(o);
    qx.push_back(xv); qgap.push_back(gap); qst.push_back(st);
  endtask

  task automatic run_queue();
    int n = qa.size(), mm = 0, fi = -1;
    exp_t e;
    for (int i = 0; i < n; i++)
      if (qx[i] != ref_alu(qa[i], qb[i], qop[i])) begin
        mm++;
        if (fi < 0) fi = i;
      end
    e.vec  = n > 255 ? 255 : n;
    e.err  = mm > 255 ? 255 : mm;
    e.idx  = fi < 0 ? 0 : (fi + 1 > 255 ? 255 : fi + 1);
    e.op   = fi < 0 ? 0 : qop[fi];
    e.got  = fi < 0 ? 0 : qx[fi];
    e.pass = mm == 0 ? 1 : 0;
    last_vec = e.vec;
    @(negedge clk);
    start = 1; in_valid = 0; in_last = 0;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < qgap[i]; g++) begin
        @(negedge clk);
        start = 0; in_valid = 0; in_last = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      start = qst[i]; in_valid = 1; in_last = (i == n - 1);
      a = W'(qa[i]); b = W'(qb[i]); op = 3'(qop[i]); xin = W'(qx[i]);
      if (i == n - 1) begin
        e.dcyc = cyc + 1 + LAT;
        sb.push_back(e);
      end
    end
    @(negedge clk);
    start = 0; in_valid = 0; in_last = 0;
    for (int k = 0; k < LAT + 4 && !done; k++) @(negedge clk);
    chk("done_timeout", int'(done), 1);
    qa.delete(); qb.delete(); qop.delete(); qx.delete(); qgap.delete(); qst.delete();
  endtask

  task automatic idle_frozen(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = ~in_valid; in_last = 1; a = W'($urandom); op = 3'($urandom);
    end
    @(negedge clk);
    in_valid = 0; in_last = 0;
    chk("frozen_done", int'(done), 1);
    chk("frozen_vec", int'(vec_count), last_vec);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int av, bv, o, r, n;
    repeat (2) @(negedge clk);
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = ~in_valid; in_last = 1;
    end
    @(negedge clk);
    in_valid = 0; in_last = 0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_vec", int'(vec_count), 0);
    chk("rst_err", int'(err_count), 0);
    chk("rst_idx", int'(first_err_idx), 0);
    chk("rst_op", int'(first_err_op), 0);
    chk("rst_got", int'(first_err_got), 0);

    for (int k = 0; k < 8; k++) push_vec(4, 6, k, ref_alu(4, 6, k));
    run_queue();
    idle_frozen(4);

    for (int k = 0; k < 8; k++) push_vec(4, 6, k, k == 5 ? 0 : ref_alu(4, 6, k));
    run_queue();

    push_vec(15, 1, 0, ref_alu(15, 1, 0));
    push_vec(0, 1, 1, ref_alu(0, 1, 1));
    run_queue();
    idle_frozen(3);

    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0; in_valid = 1; in_last = 0; a = 1; b = 2; op = 0; xin = 3;
    @(negedge clk);
    a = 3; xin = 5; rst = 1;
    @(negedge clk);
    rst = 0; in_valid = 0;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_vec", int'(vec_count), 0);
    repeat (LAT + 2) @(negedge clk);
    chk("midrst_vec_late", int'(vec_count), 0);
    chk("midrst_done", int'(done), 0);
    av = int'($urandom_range(0, 15)); bv = int'($urandom_range(0, 15)); o = int'($urandom_range(0, 7));
    push_vec(av, bv, o, ref_alu(av, bv, o));
    run_queue();

    for (int i = 0; i < 300; i++) begin
      av = int'($urandom_range(0, 15)); bv = int'($urandom_range(0, 15)); o = int'($urandom_range(0, 7));
      r = ref_alu(av, bv, o) ^ int'($urandom_range(1, 15));
      push_vec(av, bv, o, r, 0, (i % 50) == 25);
    end
    run_queue();

    repeat (6) begin
      n = int'($urandom_range(1, 20));
      for (int i = 0; i < n; i++) begin
        av = int'($urandom_range(0, 15)); bv = int'($urandom_range(0, 15)); o = int'($urandom_range(0, 7));
        r = ref_alu(av, bv, o);
        if ($urandom_range(0, 4) == 0) r = r ^ int'($urandom_range(1, 15));
        push_vec(av, bv, o, r, int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)));
      end
      run_queue();
    end

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
